// File: rtl/spfp_pkg.sv
// Shared types and constants for the sequential single-precision add/subtract unit.
package spfp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned SIG_W     = FRAC_W + 1;          // significand with hidden bit
  localparam int unsigned GRS_W     = 3;                   // guard, round, sticky
  localparam int unsigned ALN_W     = SIG_W + GRS_W;       // aligned operand width
  localparam int unsigned MANT_W    = ALN_W + 1;           // plus carry-out
  localparam int unsigned SHIFT_MAX = 26;                  // alignment shift saturation
  localparam int unsigned WIDE_W    = SIG_W + GRS_W + SHIFT_MAX;
  localparam int unsigned XEXP_W    = 10;                  // signed working exponent
  localparam int unsigned SHAMT_W   = 5;

  localparam int unsigned EXP_BIAS  = 127;
  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } spfp_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/spfp_addsub_seq_unpack_classify.sv
// Splits a single-precision word into fields and flags; denormals read as signed zero.
module spfp_unpack_classify
  import spfp_pkg::*;
(
  input  logic [WORD_W-1:0] op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [SIG_W-1:0]  sig_o,
  output logic              is_zero_o,
  output logic              is_inf_o,
  output logic              is_nan_o
);

  spfp_t op;
  logic  exp_zero;
  logic  exp_max;
  logic  frac_zero;

  assign op = op_i;

  // Field decode with flush-to-zero of denormals
  always_comb begin
    exp_zero  = (op.exp == '0);
    exp_max   = (op.exp == EXP_MAX);
    frac_zero = (op.frac == '0);
    sign_o    = op.sign;
    exp_o     = exp_zero ? '0 : op.exp;
    sig_o     = exp_zero ? '0 : {1'b1, op.frac};
    is_zero_o = exp_zero;
    is_inf_o  = exp_max & frac_zero;
    is_nan_o  = exp_max & ~frac_zero;
  end

endmodule

// File: rtl/spfp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with valid/ready on both sides.
module spfp_addsub_seq
  import spfp_pkg::*;
#(
  parameter int unsigned NORM_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] n1,
  input  logic [WORD_W-1:0] n2,
  input  logic              add_or_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] z,
  output logic              busy
);

  state_t                     state_q, state_d;
  logic                       align_ph_q, align_ph_d;
  logic [WORD_W-1:0]          opa_q, opa_d, opb_q, opb_d;
  logic                       op_add_q, op_add_d;
  logic                       special_q, special_d;
  logic                       sign_q, sign_d;
  logic                       eff_sub_q, eff_sub_d;
  logic signed [XEXP_W-1:0]   exp_q, exp_d;
  logic [SIG_W-1:0]           sig_big_q, sig_big_d, sig_small_q, sig_small_d;
  logic [SHAMT_W-1:0]         shamt_q, shamt_d;
  logic [ALN_W-1:0]           big_q, big_d, small_q, small_d;
  logic [MANT_W-1:0]          mant_q, mant_d;
  logic [WORD_W-1:0]          z_q, z_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;

  logic                       a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0]           a_exp, b_exp;
  logic [SIG_W-1:0]           a_sig, b_sig;

  logic                       sb_eff;
  logic                       a_ge;
  logic [EXP_W-1:0]           diff;
  logic [SHAMT_W-1:0]         shamt;
  logic [WIDE_W-1:0]          wide;
  logic [ALN_W-1:0]           aligned;
  logic [MANT_W-1:0]          sum;
  logic [SHAMT_W-1:0]         lz;
  logic [SHAMT_W-1:0]         step;
  logic signed [XEXP_W-1:0]   exp_n;
  logic                       rnd;
  logic [SIG_W:0]             sig_r;
  logic signed [XEXP_W-1:0]   exp_r;
  logic [FRAC_W-1:0]          frac_r;

  spfp_unpack_classify u_cls_a (
    .op_i      (opa_q),
    .sign_o    (a_sign),
    .exp_o     (a_exp),
    .sig_o     (a_sig),
    .is_zero_o (a_zero),
    .is_inf_o  (a_inf),
    .is_nan_o  (a_nan)
  );

  spfp_unpack_classify u_cls_b (
    .op_i      (opb_q),
    .sign_o    (b_sign),
    .exp_o     (b_exp),
    .sig_o     (b_sig),
    .is_zero_o (b_zero),
    .is_inf_o  (b_inf),
    .is_nan_o  (b_nan)
  );

  // Per-stage arithmetic: ordering, alignment shift, add, leading-zero count, rounding
  always_comb begin
    sb_eff  = b_sign ^ ~op_add_q;
    a_ge    = {a_exp, a_sig} >= {b_exp, b_sig};
    diff    = a_ge ? (a_exp - b_exp) : (b_exp - a_exp);
    shamt   = (diff > EXP_W'(SHIFT_MAX)) ? SHAMT_W'(SHIFT_MAX) : diff[SHAMT_W-1:0];
    wide    = {sig_small_q, {(GRS_W + SHIFT_MAX){1'b0}}} >> shamt_q;
    aligned = {wide[WIDE_W-1 -: ALN_W-1], wide[SHIFT_MAX] | (|wide[SHIFT_MAX-1:0])};
    sum     = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                        : ({1'b0, big_q} + {1'b0, small_q});
    lz      = SHAMT_W'(SHIFT_MAX);
    for (int i = 0; i < ALN_W; i++) begin
      if (mant_q[i]) lz = SHAMT_W'(SHIFT_MAX - i);
    end
    step    = (lz < SHAMT_W'(NORM_SHIFT)) ? lz : SHAMT_W'(NORM_SHIFT);
    exp_n   = exp_q - signed'(XEXP_W'(step));
    rnd     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    sig_r   = {1'b0, mant_q[MANT_W-2:GRS_W]} + (SIG_W+1)'(rnd);
    exp_r   = exp_q + signed'(XEXP_W'(sig_r[SIG_W]));
    frac_r  = sig_r[SIG_W] ? sig_r[SIG_W-1:1] : sig_r[FRAC_W-1:0];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    align_ph_d  = align_ph_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_add_d    = op_add_q;
    special_d   = special_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    exp_d       = exp_q;
    sig_big_d   = sig_big_q;
    sig_small_d = sig_small_q;
    shamt_d     = shamt_q;
    big_d       = big_q;
    small_d     = small_q;
    mant_d      = mant_q;
    z_d         = z_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d      = n1;
          opb_d      = n2;
          op_add_d   = add_or_sub;
          align_ph_d = 1'b0;
          state_d    = ALIGN;
        end
      end

      ALIGN: begin
        if (!align_ph_q) begin
          // Phase 0: classify, resolve special cases, order by magnitude
          align_ph_d = 1'b1;
          special_d  = 1'b1;
          eff_sub_d  = a_sign ^ sb_eff;
          if (a_nan || b_nan) begin
            z_d = QNAN;
          end else if (a_inf && b_inf) begin
            z_d = (a_sign != sb_eff) ? QNAN : {a_sign, POS_INF[WORD_W-2:0]};
          end else if (a_inf) begin
            z_d = {a_sign, POS_INF[WORD_W-2:0]};
          end else if (b_inf) begin
            z_d = {sb_eff, POS_INF[WORD_W-2:0]};
          end else if (a_zero && b_zero) begin
            z_d = {a_sign & sb_eff, {(WORD_W-1){1'b0}}};
          end else if (a_zero) begin
            z_d = {sb_eff, opb_q[WORD_W-2:0]};
          end else if (b_zero) begin
            z_d = {a_sign, opa_q[WORD_W-2:0]};
          end else begin
            special_d = 1'b0;
            shamt_d   = shamt;
            if (a_ge) begin
              sign_d      = a_sign;
              exp_d       = signed'(XEXP_W'(a_exp));
              sig_big_d   = a_sig;
              sig_small_d = b_sig;
            end else begin
              sign_d      = sb_eff;
              exp_d       = signed'(XEXP_W'(b_exp));
              sig_big_d   = b_sig;
              sig_small_d = a_sig;
            end
          end
        end else begin
          // Phase 1: right-shift the smaller significand with sticky collection
          if (special_q) begin
            state_d = DONE;
          end else begin
            big_d   = {sig_big_q, {GRS_W{1'b0}}};
            small_d = aligned;
            state_d = ADD;
          end
        end
      end

      ADD: begin
        if (sum == '0) begin
          z_d     = '0;
          state_d = DONE;
        end else begin
          mant_d  = sum;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mant_q[MANT_W-1]) begin
          mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + signed'(XEXP_W'(1));
          state_d = ROUND;
        end else begin
          mant_d = mant_q << step;
          exp_d  = exp_n;
          if (exp_n <= signed'(XEXP_W'(0))) begin
            z_d     = {sign_q, {(WORD_W-1){1'b0}}};
            state_d = DONE;
          end else if (lz <= SHAMT_W'(NORM_SHIFT)) begin
            state_d = ROUND;
          end
        end
      end

      ROUND: begin
        if (exp_r >= signed'(XEXP_W'(EXP_MAX))) begin
          z_d = {sign_q, POS_INF[WORD_W-2:0]};
        end else begin
          z_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      align_ph_q  <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_add_q    <= 1'b0;
      special_q   <= 1'b0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      sig_big_q   <= '0;
      sig_small_q <= '0;
      shamt_q     <= '0;
      big_q       <= '0;
      small_q     <= '0;
      mant_q      <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_ph_q  <= align_ph_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_add_q    <= op_add_d;
      special_q   <= special_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      exp_q       <= exp_d;
      sig_big_q   <= sig_big_d;
      sig_small_q <= sig_small_d;
      shamt_q     <= shamt_d;
      big_q       <= big_d;
      small_q     <= small_d;
      mant_q      <= mant_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign z         = z_q;

endmodule

// File: tb/tb_spfp_addsub_seq.sv
// Directed-vector bench for spfp_addsub_seq (NORM_SHIFT=1 and NORM_SHIFT=8 instances).
module tb_spfp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid8 = 1'b0;
  logic        out_ready = 1'b0, out_ready8 = 1'b0;
  logic [31:0] n1 = '0, n2 = '0;
  logic        add_or_sub = 1'b0;

  logic        in_ready, out_valid, busy;
  logic [31:0] z;
  logic        in_ready8, out_valid8, busy8;
  logic [31:0] z8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spfp_addsub_seq #(.NORM_SHIFT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n1         (n1),
    .n2         (n2),
    .add_or_sub (add_or_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .busy       (busy)
  );

  spfp_addsub_seq #(.NORM_SHIFT(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .n1         (n1),
    .n2         (n2),
    .add_or_sub (add_or_sub),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .z          (z8),
    .busy       (busy8)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One transaction: accept, measure latency to out_valid, check z, drain.
  task automatic run_op(input bit use8, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] exp_z, input int exp_lat,
                        input string tag);
    int cyc;
    @(negedge clk);
    check_eq({tag, ":in_ready"}, 64'(use8 ? in_ready8 : in_ready), 64'(1));
    n1 = a; n2 = b; add_or_sub = op;
    if (use8) in_valid8 = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid8 = 1'b0;
    check_eq({tag, ":rdy_busy"}, 64'(use8 ? {in_ready8, busy8} : {in_ready, busy}), 64'(2'b01));
    cyc = 0;
    while (!(use8 ? out_valid8 : out_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, ":z"}, 64'(use8 ? z8 : z), 64'(exp_z));
    if (use8) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready8 = 1'b0;
    check_eq({tag, ":drain"}, 64'(use8 ? {out_valid8, in_ready8} : {out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    check_eq("reset_z", 64'(z), 64'(0));
    check_eq("reset_flags8", 64'({in_ready8, out_valid8, busy8, z8}), 64'({3'b100, 32'h0}));
    rst_n = 1'b1;

    run_op(0, 32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 5,  "add_1_2");
    run_op(0, 32'h3F800001, 32'h3F800000, 1'b0, 32'h34000000, 27, "sub_ulp_ns1");
    run_op(1, 32'h3F800001, 32'h3F800000, 1'b0, 32'h34000000, 7,  "sub_ulp_ns8");
    run_op(0, 32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 5,  "tie_even");
    run_op(0, 32'h3F800000, 32'h33800001, 1'b1, 32'h3F800001, 5,  "above_tie");
    run_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 3,  "cancel");
    run_op(0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F7FFFFF, 5,  "sub_borrow");
    run_op(0, 32'h3F800000, 32'h0C000000, 1'b1, 32'h3F800000, 5,  "far_sticky");
    run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 5,  "ovf_inf");
    run_op(0, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 2,  "inf_m_inf");
    run_op(0, 32'h00000001, 32'h80000000, 1'b1, 32'h00000000, 2,  "denorm_zero");
    run_op(0, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 2,  "negz_negz");
    run_op(0, 32'h00000000, 32'h3F800000, 1'b0, 32'hBF800000, 2,  "zero_minus_x");
    run_op(0, 32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 2,  "nan_in");
    run_op(0, 32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 2,  "ninf_fin");

    // Backpressure: hold result in DONE while a stray request is presented
    @(negedge clk);
    n1 = 32'h3F800000; n2 = 32'h40000000; add_or_sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("bp_latency", 64'(cyc), 64'(5));
    n1 = 32'h40400000; n2 = 32'h3F800000; add_or_sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold", 64'({out_valid, in_ready, busy, z}), 64'({3'b101, 32'h40400000}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    run_op(0, 32'h40400000, 32'h3F800000, 1'b0, 32'h40000000, 5, "bp_next");

    // Asynchronous reset while normalising
    @(negedge clk);
    n1 = 32'h3F800001; n2 = 32'h3F800000; add_or_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_busy", 64'({busy, out_valid}), 64'(2'b10));
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", 64'({in_ready, out_valid, busy, z}), 64'({3'b100, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'h40400000, 32'hBF800000, 1'b1, 32'h40000000, 5, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
